hiscore_uploader: RTL and testbench

HISCORE_UPLOADER -- requirements
Module: hiscore_uploader

---
 rtl/hiscore_pkg.sv | 15 +
 rtl/hiscore_uploader.sv | 136 +++++++++++++
 tb/tb_hiscore_uploader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_pkg.sv
// Shared definitions for the high-score upload path.
package hiscore_pkg;

  localparam logic [7:0] UP_INDEX_DEF = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    READY,
    FETCH,
    LATCH,
    RELEASE
  } state_t;

endpackage

// File: rtl/hiscore_uploader.sv
// Serves game-RAM bytes to the HPS during an ioctl upload session.
// Before touching RAM it halts the game CPU, keeps one strobe in reserve,
// and answers out-of-range addresses with 8'hFF without stalling.
module hiscore_uploader
  import hiscore_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter int unsigned DUMP_SIZE = 1024,
  parameter logic [7:0]  UP_INDEX  = UP_INDEX_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_index,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_pause,
  input  logic              pause_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy
);

  localparam logic [24:0] DUMP_LIM = 25'(DUMP_SIZE);

  state_t            state, state_n;
  logic              qual, qual_q, fall;
  logic              rd_act, rd_in, rd_oob;
  logic              pend_v, pend_v_n;
  logic [RAM_AW-1:0] pend_addr, pend_addr_n;
  logic              redo, redo_n;
  logic              issue, latch, rd_direct;
  logic [RAM_AW-1:0] issue_addr;

  assign qual   = ioctl_upload && (ioctl_index == UP_INDEX);
  assign fall   = qual_q && !qual;
  assign rd_act = qual && ioctl_rd && (state inside {PAUSE, READY, FETCH, LATCH});
  // Range check on the full address; truncation happens only when issuing.
  assign rd_in  = rd_act && (ioctl_addr < DUMP_LIM);
  assign rd_oob = rd_act && !(ioctl_addr < DUMP_LIM);

  assign busy       = (state != IDLE);
  assign cpu_pause  = state inside {PAUSE, READY, FETCH, LATCH};
  assign ioctl_wait = (state inside {PAUSE, FETCH, LATCH}) ||
                      ((state == READY) && (pend_v || redo));

  // Next-state, read issue and captured-strobe slot bookkeeping.
  always_comb begin
    state_n     = state;
    issue       = 1'b0;
    issue_addr  = ram_addr;
    latch       = 1'b0;
    rd_direct   = 1'b0;
    redo_n      = redo;
    pend_v_n    = pend_v;
    pend_addr_n = pend_addr;
    case (state)
      IDLE: if (qual && !qual_q) state_n = PAUSE;
      PAUSE: begin
        if (fall)           state_n = RELEASE;
        else if (pause_ack) state_n = READY;
      end
      READY: begin
        if (fall)            state_n = RELEASE;
        else if (!pause_ack) state_n = PAUSE;
        else if (redo) begin
          // ram_addr still holds the interrupted address.
          issue   = 1'b1;
          redo_n  = 1'b0;
          state_n = FETCH;
        end else if (pend_v) begin
          issue      = 1'b1;
          issue_addr = pend_addr;
          pend_v_n   = 1'b0;
          state_n    = FETCH;
        end else if (rd_in) begin
          issue      = 1'b1;
          issue_addr = ioctl_addr[RAM_AW-1:0];
          rd_direct  = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH, LATCH: begin
        if (fall) state_n = RELEASE;
        else if (!pause_ack) begin
          redo_n  = 1'b1;
          state_n = PAUSE;
        end else if (state == FETCH) begin
          state_n = LATCH;
        end else begin
          latch   = 1'b1;
          state_n = READY;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Slot freed by this cycle's issue can take a strobe arriving now.
    if (rd_in && !rd_direct && !pend_v_n) begin
      pend_v_n    = 1'b1;
      pend_addr_n = ioctl_addr[RAM_AW-1:0];
    end
    if (state_n == RELEASE) begin
      pend_v_n = 1'b0;
      redo_n   = 1'b0;
    end
  end

  // State, edge detect, strobe slot and RAM/HPS output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      qual_q    <= 1'b1;  // a session already running at reset needs a fresh edge
      pend_v    <= 1'b0;
      pend_addr <= '0;
      redo      <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      ioctl_din <= '0;
    end else begin
      state     <= state_n;
      qual_q    <= qual;
      pend_v    <= pend_v_n;
      pend_addr <= pend_addr_n;
      redo      <= redo_n;
      ram_rd    <= issue;
      if (issue) ram_addr <= issue_addr;
      if (latch)       ioctl_din <= ram_q;
      else if (rd_oob) ioctl_din <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_hiscore_uploader.sv
// Directed bench for hiscore_uploader with a behavioural game RAM.
module tb_hiscore_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_pause;
  logic        pause_ack;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q = 8'h00;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int p0;
  logic [7:0] mem [0:1023];
  logic [7:0] e;

  hiscore_uploader #(.RAM_AW(10), .DUMP_SIZE(1024), .UP_INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .cpu_pause(cpu_pause),
    .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_q     <= mem[ram_addr];
      rd_pulses <= rd_pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},   32'(ioctl_din), 32'h00);
    check({tag, "_wait"},  32'(ioctl_wait), 32'd0);
    check({tag, "_pause"}, 32'(cpu_pause), 32'd0);
    check({tag, "_ramrd"}, 32'(ram_rd), 32'd0);
    check({tag, "_raddr"}, 32'(ram_addr), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    ioctl_index = 8'd4; pause_ack = 1'b0;
    reset = 1'b1;
    #12;
    check_reset_outputs("rst0");
    tick();
    reset = 1'b0;
    tick(); tick();

    // Session start, strobe at addr 0 captured while paused
    ioctl_upload = 1'b1;
    tick();
    check("start_pause", 32'(cpu_pause), 32'd1);
    check("start_busy",  32'(busy), 32'd1);
    check("start_wait",  32'(ioctl_wait), 32'd1);
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    tick();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pause_wait",  32'(ioctl_wait), 32'd1);
      check("pause_noram", 32'(ram_rd), 32'd0);
      tick();
    end
    pause_ack = 1'b1;
    tick();
    check("ready_wait", 32'(ioctl_wait), 32'd1);
    tick();
    check("p_ramrd", 32'(ram_rd), 32'd1);
    check("p_raddr", 32'(ram_addr), 32'd0);
    tick();
    check("p_latch_wait", 32'(ioctl_wait), 32'd1);
    tick();
    check("p_din",  32'(ioctl_din), 32'h5A);
    check("p_wait", 32'(ioctl_wait), 32'd0);

    // Two-cycle latency from a strobe taken in READY
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    check("lat_ramrd", 32'(ram_rd), 32'd1);
    check("lat_wait",  32'(ioctl_wait), 32'd1);
    tick();
    tick();
    check("lat_din",  32'(ioctl_din), 32'h59);
    check("lat_wait0", 32'(ioctl_wait), 32'd0);

    // Full sequential dump
    for (int n = 0; n < 1024; n++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(n);
      tick();
      ioctl_rd = 1'b0;
      tick(); tick();
      e = 8'(n) ^ 8'h5A;
      check("dump_din",   32'(ioctl_din), 32'(e));
      check("dump_pause", 32'(cpu_pause), 32'd1);
    end

    // Out-of-range addresses
    p0 = rd_pulses;
    ioctl_rd = 1'b1; ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    check("oob1024_din",  32'(ioctl_din), 32'hFF);
    check("oob1024_wait", 32'(ioctl_wait), 32'd0);
    check("oob1024_rd",   32'(ram_rd), 32'd0);
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick();
    ioctl_rd = 1'b0;
    tick(); tick();
    check("mid_din", 32'(ioctl_din), 32'h5F);
    ioctl_rd = 1'b1; ioctl_addr = 25'h1FFFFFF;
    tick();
    ioctl_rd = 1'b0;
    check("oobmax_din",  32'(ioctl_din), 32'hFF);
    check("oobmax_wait", 32'(ioctl_wait), 32'd0);
    tick();
    check("oob_pulses", 32'(rd_pulses - p0), 32'd1);

    // Back-to-back strobes 5, 6, 7: third dropped
    p0 = rd_pulses;
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick();
    ioctl_addr = 25'd6;
    tick();
    ioctl_addr = 25'd7;
    tick();
    ioctl_rd = 1'b0;
    check("b2b_din5",  32'(ioctl_din), 32'h5F);
    check("b2b_wait5", 32'(ioctl_wait), 32'd1);
    tick(); tick(); tick();
    check("b2b_din6",  32'(ioctl_din), 32'h5C);
    check("b2b_wait6", 32'(ioctl_wait), 32'd0);
    check("b2b_addr6", 32'(ram_addr), 32'd6);
    tick(); tick();
    check("b2b_pulses", 32'(rd_pulses - p0), 32'd2);
    check("b2b_hold",   32'(ioctl_din), 32'h5C);

    // Acknowledge lost mid-fetch: re-issue after re-ack
    ioctl_rd = 1'b1; ioctl_addr = 25'd9;
    tick();
    ioctl_rd = 1'b0; pause_ack = 1'b0;
    tick();
    check("nack_wait",  32'(ioctl_wait), 32'd1);
    check("nack_pause", 32'(cpu_pause), 32'd1);
    check("nack_din",   32'(ioctl_din), 32'h5C);
    pause_ack = 1'b1;
    tick();
    check("reack_wait", 32'(ioctl_wait), 32'd1);
    tick();
    check("reack_ramrd", 32'(ram_rd), 32'd1);
    check("reack_raddr", 32'(ram_addr), 32'd9);
    tick(); tick();
    check("reack_din",  32'(ioctl_din), 32'h53);
    check("reack_wait0", 32'(ioctl_wait), 32'd0);

    // Upload dropped during FETCH
    ioctl_rd = 1'b1; ioctl_addr = 25'd20;
    tick();
    ioctl_rd = 1'b0;
    check("abort_ramrd", 32'(ram_rd), 32'd1);
    ioctl_upload = 1'b0;
    tick();
    check("abort_pause", 32'(cpu_pause), 32'd0);
    check("abort_busy1", 32'(busy), 32'd1);
    tick();
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_wait",  32'(ioctl_wait), 32'd0);
    check("abort_din",   32'(ioctl_din), 32'h53);
    pause_ack = 1'b0;

    // Foreign index is ignored
    p0 = rd_pulses;
    ioctl_index = 8'd0; ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check("idx0_pause",  32'(cpu_pause), 32'd0);
    check("idx0_busy",   32'(busy), 32'd0);
    check("idx0_wait",   32'(ioctl_wait), 32'd0);
    check("idx0_pulses", 32'(rd_pulses - p0), 32'd0);
    check("idx0_din",    32'(ioctl_din), 32'h53);

    // Mid-session reset
    ioctl_upload = 1'b0; ioctl_index = 8'd4;
    tick();
    ioctl_upload = 1'b1;
    tick();
    check("s2_busy", 32'(busy), 32'd1);
    pause_ack = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    check("s2_ramrd", 32'(ram_rd), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst1");
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("norestart_busy",  32'(busy), 32'd0);
    check("norestart_pause", 32'(cpu_pause), 32'd0);
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    check("restart_busy",  32'(busy), 32'd1);
    check("restart_pause", 32'(cpu_pause), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
